game_countdown: RTL
===================

GAME_COUNTDOWN -- requirements
Module: game_countdown

Interface
REQ-001 SHALL have parameter START_SECS, default 31, giving the initial/reload seconds (legal range 1..99).
REQ-002 SHALL have parameter TICK_CYCLES, default 100000000, giving the clk cycles per one-second decrement (legal range >=2).
REQ-003 SHALL have parameter BONUS_SECS, default 5, giving the seconds added per add_time pulse (legal range 0..99).
REQ-004 SHALL have parameter WARN_SECS, default 5, giving the low-time threshold (used only under REQ-024).
REQ-005 SHALL have ports: clk  in  1  system clock, rising edge; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have inputs: enable  in  1  start/resume qualifier; pause  in  1  hold request (level); restart  in  1  reload-and-idle pulse; add_time  in  1  bonus-seconds pulse.
REQ-007 SHALL have outputs: time_MSB_ascii  out  8  ASCII tens digit; time_LSB_ascii  out  8  ASCII ones digit; secs_left  out  7  binary seconds remaining; tick  out  1  one-cycle decrement strobe; timer_done  out  1  countdown expired.

Function
REQ-008 SHALL store remaining time as two BCD digits (tens 0..9, ones 0..9); time_MSB_ascii = 8'h30+tens; time_LSB_ascii = 8'h30+ones; secs_left = tens*10+ones; all are registered-state decodes with no added latency.
REQ-009 SHALL implement FSM states IDLE, RUNNING, PAUSED, DONE.
REQ-010 Event priority per cycle, highest first: rst > restart > pause > (tick decrement, add_time).
REQ-011 IDLE: digits hold START_SECS; go to RUNNING when enable=1 (and pause=0); pause=1 in IDLE is ignored, and the state stays IDLE.
REQ-012 RUNNING: prescaler counts 0..TICK_CYCLES-1; on the edge where it equals TICK_CYCLES-1 it wraps to 0, digits decrement by 1 with BCD borrow (ones 0 -> 9, tens-1), and tick is high for the following cycle only.
REQ-013 First decrement SHALL occur TICK_CYCLES cycles after the edge entering RUNNING from IDLE.
REQ-014 RUNNING with pause=1: go to PAUSED; the prescaler holds and no decrement occurs that edge, even if the prescaler is at terminal count.
REQ-015 PAUSED: prescaler and digits hold; return to RUNNING when pause=0 and enable=1; the prescaler resumes from its held value; enable is otherwise ignored in RUNNING.
REQ-016 A decrement from 1 to 0 SHALL move the FSM to DONE on the same edge; timer_done = (state==DONE), so it rises in the same cycle secs_left first reads 0.
REQ-017 DONE: digits 00 and held; enable, pause and add_time are ignored; exit only via rst or restart.
REQ-018 restart=1 in any state: digits reload START_SECS, prescaler to 0, tick to 0, and the FSM goes to IDLE on that edge.
REQ-019 add_time=1 in RUNNING or PAUSED: remaining time increases by BONUS_SECS, saturating at 99; add_time is ignored in IDLE and DONE.
REQ-020 add_time coincident with a decrement: result = min(99, value+BONUS_SECS-1); no DONE transition occurs if the result is >0.
REQ-021 add_time is edge-free level sampling: each cycle it is high counts once; the source supplies single-cycle pulses.

Reset
REQ-022 On rst=1 at a clk edge: state IDLE, digits START_SECS, prescaler 0, tick 0; therefore timer_done 0, secs_left START_SECS, and the ASCII outputs are the START_SECS digits (31 -> 8'h33/8'h31).
REQ-023 rst mid-count SHALL discard the prescaler phase, and no tick SHALL be emitted in the cycle after reset.

Configuration
REQ-024 With macro GAME_COUNTDOWN_WARN_EN defined: the block SHALL add output low_time  out  1, high when state is RUNNING or PAUSED and 0 < secs_left <= WARN_SECS, else 0, and 0 after reset.
REQ-025 Without GAME_COUNTDOWN_WARN_EN: the low_time port and its logic SHALL be absent, and all other behaviour is identical.

Verification (TICK_CYCLES=4 unless noted)
REQ-026 rst, then enable pulse -> secs_left 31 for 4 cycles, then 30, ASCII 8'h33/8'h30, tick high exactly one cycle.
REQ-027 START_SECS=3: run uninterrupted -> 00 after 12 RUNNING cycles, timer_done=1 in the same cycle, and held through later enable/pause/add_time pulses.
REQ-028 Pause with prescaler at 2 for 10 cycles, then resume -> no change while paused, next decrement 2 cycles after resume; pause at terminal count -> no decrement.
REQ-029 BONUS_SECS=5: add_time at 97 -> 99; add_time coincident with a decrement at 10 -> 14; BCD borrow 20 -> 19 gives ASCII 8'h31/8'h39.
REQ-030 restart while DONE, and separately while RUNNING at 17 -> IDLE, secs_left 31, timer_done 0, no tick until re-enabled.
REQ-031 With GAME_COUNTDOWN_WARN_EN, WARN_SECS=5 -> low_time rises when secs_left becomes 5, falls when timer_done rises, and falls when add_time lifts secs_left to 9.

Source files
------------

// File: rtl/game_countdown.sv
// game_countdown: two-digit BCD game timer with pause, bonus seconds and restart.
// Defining GAME_COUNTDOWN_WARN_EN adds the low_time warning output.
module game_countdown #(
    parameter int START_SECS  = 31,
    parameter int TICK_CYCLES = 100000000,
    parameter int BONUS_SECS  = 5,
    parameter int WARN_SECS   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pause,
    input  logic       restart,
    input  logic       add_time,
    output logic [7:0] time_MSB_ascii,
    output logic [7:0] time_LSB_ascii,
    output logic [6:0] secs_left,
    output logic       tick,
    output logic       timer_done
`ifdef GAME_COUNTDOWN_WARN_EN
    ,
    output logic       low_time
`endif
);
    localparam int PW = TICK_CYCLES > 2 ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TERM = PW'(TICK_CYCLES - 1);
    localparam logic [3:0] START_T = 4'(START_SECS / 10);
    localparam logic [3:0] START_O = 4'(START_SECS % 10);

    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    tens, ones, tens_nxt, ones_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          tick_nxt, dec;
    logic [7:0]    sum;
    logic [6:0]    sat;

    assign secs_left      = 7'(tens) * 7'd10 + 7'(ones);
    assign time_MSB_ascii = 8'h30 + {4'h0, tens};
    assign time_LSB_ascii = 8'h30 + {4'h0, ones};
    assign timer_done     = state == DONE;
    assign dec            = state == RUNNING && presc == TERM;

    // bonus and a coincident decrement are folded into one saturating sum
    always_comb begin
        sum = 8'(secs_left) + (add_time ? 8'(BONUS_SECS) : 8'd0) - {7'd0, dec};
        sat = sum > 8'd99 ? 7'd99 : sum[6:0];
    end

    always_comb begin
        state_nxt = state;
        tens_nxt  = tens;
        ones_nxt  = ones;
        presc_nxt = presc;
        tick_nxt  = 1'b0;
        if (restart) begin
            state_nxt = IDLE;
            tens_nxt  = START_T;
            ones_nxt  = START_O;
            presc_nxt = '0;
        end else begin
            case (state)
                IDLE: state_nxt = enable && !pause ? RUNNING : IDLE;
                RUNNING: begin
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else begin
                        presc_nxt = dec ? '0 : presc + 1'b1;
                        tick_nxt  = dec;
                        if (add_time) begin
                            tens_nxt = 4'(sat / 7'd10);
                            ones_nxt = 4'(sat % 7'd10);
                        end else if (dec) begin
                            ones_nxt = ones == 4'd0 ? 4'd9 : ones - 4'd1;
                            tens_nxt = ones == 4'd0 ? tens - 4'd1 : tens;
                        end
                        if (dec && sat == 7'd0) state_nxt = DONE;
                    end
                end
                PAUSED: begin
                    if (add_time) begin
                        tens_nxt = 4'(sat / 7'd10);
                        ones_nxt = 4'(sat % 7'd10);
                    end
                    if (!pause && enable) state_nxt = RUNNING;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tens  <= START_T;
            ones  <= START_O;
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            state <= state_nxt;
            tens  <= tens_nxt;
            ones  <= ones_nxt;
            presc <= presc_nxt;
            tick  <= tick_nxt;
        end
    end

`ifdef GAME_COUNTDOWN_WARN_EN
    assign low_time = (state == RUNNING || state == PAUSED) && secs_left != 7'd0 && secs_left <= 7'(WARN_SECS);
`endif
endmodule
